lcd_id_detect: RTL and testbench
================================

# lcd_id_detect

Parametrised LCD panel identification block for the RGB LCD path. After reset, or on request, it waits a settle interval, samples the panel strap pins on the shared `lcd_rgb` bus until they hold stable, and decodes them into a panel ID and active resolution. It is the successor to the single-shot strap reader. It adds settle delay, glitch filtering, timeout, re-detect and error reporting. It sits between the LCD pad bus and the timing generator, which consumes `lcd_id`, `h_disp` and `v_disp` once `id_valid` is high.

## Interface
- `SETTLE_CYC`, default 1000: cycles to wait after reset or `rd_req` before sampling starts (≥1).
- `STABLE_CNT`, default 16: number of consecutive identical strap samples required to accept a code (≥2).
- `TIMEOUT_CYC`, default 4096: maximum cycles spent in SAMPLE before an error is declared (>`STABLE_CNT`).

- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `lcd_rgb` input 16: LCD pixel bus; strap code = {`lcd_rgb[4]`, `lcd_rgb[10]`, `lcd_rgb[15]`} (M2:B4, M1:G5, M0:R4).
- `rd_req` input 1: single-cycle pulse requesting re-detection.
- `lcd_id` output 16: decoded panel ID; 0 = none or unknown.
- `h_disp` output 11: active horizontal pixels.
- `v_disp` output 11: active vertical lines.
- `id_valid` output 1: high while a known ID is held.
- `id_err` output 1: high while an unknown code or timeout is held.

## Operation
- **FSM states:** SETTLE, SAMPLE, DONE, ERR. Reset enters SETTLE with all counters at 0.
- **SETTLE:**
  - `set_cnt` increments on each cycle.
  - On the edge where `set_cnt == SETTLE_CYC-1`, go to SAMPLE and clear `stb_cnt` and `to_cnt`.
- **SAMPLE (every edge):**
  - `samp_q <= strap`.
  - If `strap == samp_q` and `stb_cnt != 0`, then `stb_cnt+1`; otherwise `stb_cnt <= 1`.
  - `to_cnt` increments each edge.
- **Accept:** on an edge with `strap == samp_q` and `stb_cnt == STABLE_CNT-1`, decode `strap`. A known code goes to DONE; an unknown code goes to ERR.
- **Timeout:** on an edge with `to_cnt == TIMEOUT_CYC-1` and no accept, go to ERR. If both happen on the same edge, accept wins.
- **Decode table** (`lcd_id`, `h_disp` x `v_disp`):
  - 000 → 0x4342, 480x272
  - 001 → 0x7084, 800x480
  - 010 → 0x7016, 1024x600
  - 100 → 0x4384, 800x480
  - 101 → 0x1018, 1280x800
  - 011 and 110/111 → unknown.
- **DONE:** `id_valid=1`, `id_err=0`; outputs hold the decoded values.
- **ERR:** `id_err=1`, `id_valid=0`, `lcd_id=0`, `h_disp=0`, `v_disp=0`.
- **`rd_req`:**
  - In DONE or ERR: next edge clears `id_valid` and `id_err` and enters SETTLE. `lcd_id`, `h_disp` and `v_disp` keep their last values until the next accept or error.
  - In SETTLE or SAMPLE: ignored; the run in progress is not restarted.
- **Counter widths:** each sized with `$clog2` of its limit. Counters saturate and never wrap.

## Timing
- **Reset values:** all outputs 0, state SETTLE, all counters 0.
- **Reset mid-operation:** `rst_n` low at any edge forces reset values on that edge, regardless of state.
- **Latency, constant straps:** `id_valid` (or `id_err` for an unknown code) rises after edge `SETTLE_CYC + STABLE_CNT`. Edges are counted from the first edge with `rst_n` high, or from the edge after the one that registered `rd_req`.
- **Strap changes during SAMPLE:** any change restarts the stability run; `stb_cnt` goes to 1 on that edge.
- **Output timing:** all outputs are registered. `lcd_id`, `h_disp`, `v_disp` and the flag change on the same edge.
- **During SETTLE/SAMPLE:** `id_valid` and `id_err` are both 0. They are never both 1 at any time.

## Test plan
All scenarios use `SETTLE_CYC=8`, `STABLE_CNT=4`, `TIMEOUT_CYC=32`.
- **Known code:** straps 001 held from reset → after edge 12, `id_valid=1`, `lcd_id=0x7084`, 800x480, `id_err=0`.
- **Glitch filter:** straps 101 with a one-cycle flip to 100 at SAMPLE cycle 2 → run restarts; `lcd_id=0x1018`, 1280x800, valid after edge 15.
- **Unknown code:** straps 011 held → after edge 12, `id_err=1`, `lcd_id=0`, `id_valid=0`.
- **Timeout:** straps toggling every cycle → `id_err=1` after edge 8+32=40, `lcd_id=0`.
- **Re-detect:**
  - Start in DONE with 0x4342; change straps to 100 and pulse `rd_req` → `id_valid` drops on the next edge while `lcd_id` holds 0x4342.
  - Then 0x4384, 800x480 with `id_valid=1` after 12 further edges.
  - A second `rd_req` issued during SETTLE is ignored.
- **Reset mid-SAMPLE:** `rst_n` low for one edge at SAMPLE cycle 2 → all outputs 0, SETTLE restarts, and valid comes 12 edges after release.

Source files
------------

// File: rtl/lcd_id_detect.sv
// LCD panel strap detector: waits a settle interval, filters the strap pins on the
// RGB bus until they hold stable, then decodes them into a panel ID and resolution.
module lcd_id_detect #(
    parameter int SETTLE_CYC  = 1000,
    parameter int STABLE_CNT  = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] lcd_rgb,
    input  logic        rd_req,
    output logic [15:0] lcd_id,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        id_valid,
    output logic        id_err
);

    localparam int SET_W = (SETTLE_CYC  > 1) ? $clog2(SETTLE_CYC)  : 1;
    localparam int STB_W = (STABLE_CNT  > 1) ? $clog2(STABLE_CNT)  : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CNT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {SETTLE, SAMPLE, DONE, ERR} state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [2:0]         samp_q, samp_d;
    logic [15:0]        lcd_id_q, lcd_id_d;
    logic [10:0]        h_disp_q, h_disp_d;
    logic [10:0]        v_disp_q, v_disp_d;
    logic               id_valid_q, id_valid_d;
    logic               id_err_q, id_err_d;

    logic [2:0]         strap;
    logic               dec_known;
    logic [15:0]        dec_id;
    logic [10:0]        dec_h;
    logic [10:0]        dec_v;
    logic               strap_same;
    logic               unused_rgb;

    // Straps share pixel pins: M2 on B4, M1 on G5, M0 on R4.
    assign strap      = {lcd_rgb[4], lcd_rgb[10], lcd_rgb[15]};
    assign unused_rgb = ^{lcd_rgb[14:11], lcd_rgb[9:5], lcd_rgb[3:0]};
    assign strap_same = (strap == samp_q);

    always_comb begin
        dec_known = 1'b1;
        dec_id    = 16'h0000;
        dec_h     = 11'd0;
        dec_v     = 11'd0;
        case (strap)
            3'b000:  begin dec_id = 16'h4342; dec_h = 11'd480;  dec_v = 11'd272; end
            3'b001:  begin dec_id = 16'h7084; dec_h = 11'd800;  dec_v = 11'd480; end
            3'b010:  begin dec_id = 16'h7016; dec_h = 11'd1024; dec_v = 11'd600; end
            3'b100:  begin dec_id = 16'h4384; dec_h = 11'd800;  dec_v = 11'd480; end
            3'b101:  begin dec_id = 16'h1018; dec_h = 11'd1280; dec_v = 11'd800; end
            default: dec_known = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        set_cnt_d  = set_cnt_q;
        stb_cnt_d  = stb_cnt_q;
        to_cnt_d   = to_cnt_q;
        samp_d     = samp_q;
        lcd_id_d   = lcd_id_q;
        h_disp_d   = h_disp_q;
        v_disp_d   = v_disp_q;
        id_valid_d = id_valid_q;
        id_err_d   = id_err_q;
        case (state_q)
            SETTLE: begin
                if (set_cnt_q == SET_LAST) begin
                    state_d   = SAMPLE;
                    stb_cnt_d = '0;
                    to_cnt_d  = '0;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            SAMPLE: begin
                samp_d = strap;
                if (strap_same && stb_cnt_q != '0) begin
                    if (stb_cnt_q != '1) stb_cnt_d = stb_cnt_q + STB_W'(1);
                end else begin
                    stb_cnt_d = STB_W'(1);
                end
                if (to_cnt_q != '1) to_cnt_d = to_cnt_q + TO_W'(1);
                // An accept on the timeout edge takes priority over the timeout.
                if (strap_same && stb_cnt_q == STB_LAST) begin
                    state_d    = dec_known ? DONE : ERR;
                    lcd_id_d   = dec_id;
                    h_disp_d   = dec_h;
                    v_disp_d   = dec_v;
                    id_valid_d = dec_known;
                    id_err_d   = ~dec_known;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d    = ERR;
                    lcd_id_d   = 16'h0000;
                    h_disp_d   = 11'd0;
                    v_disp_d   = 11'd0;
                    id_valid_d = 1'b0;
                    id_err_d   = 1'b1;
                end
            end
            DONE, ERR: begin
                if (rd_req) begin
                    state_d    = SETTLE;
                    set_cnt_d  = '0;
                    id_valid_d = 1'b0;
                    id_err_d   = 1'b0;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SETTLE;
            set_cnt_q  <= '0;
            stb_cnt_q  <= '0;
            to_cnt_q   <= '0;
            samp_q     <= '0;
            lcd_id_q   <= '0;
            h_disp_q   <= '0;
            v_disp_q   <= '0;
            id_valid_q <= 1'b0;
            id_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_cnt_q  <= set_cnt_d;
            stb_cnt_q  <= stb_cnt_d;
            to_cnt_q   <= to_cnt_d;
            samp_q     <= samp_d;
            lcd_id_q   <= lcd_id_d;
            h_disp_q   <= h_disp_d;
            v_disp_q   <= v_disp_d;
            id_valid_q <= id_valid_d;
            id_err_q   <= id_err_d;
        end
    end

    assign lcd_id   = lcd_id_q;
    assign h_disp   = h_disp_q;
    assign v_disp   = v_disp_q;
    assign id_valid = id_valid_q;
    assign id_err   = id_err_q;

endmodule

// File: tb/tb_lcd_id_detect.sv
// Scoreboard bench for lcd_id_detect: stimulus queues the expected result and the cycle
// it should appear on; a monitor pops and compares whenever id_valid or id_err rises.
module tb_lcd_id_detect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] lcd_rgb;
    logic        rd_req;
    logic [15:0] lcd_id;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        id_valid;
    logic        id_err;

    lcd_id_detect #(
        .SETTLE_CYC  (8),
        .STABLE_CNT  (4),
        .TIMEOUT_CYC (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lcd_rgb  (lcd_rgb),
        .rd_req   (rd_req),
        .lcd_id   (lcd_id),
        .h_disp   (h_disp),
        .v_disp   (v_disp),
        .id_valid (id_valid),
        .id_err   (id_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        valid;
        logic        err;
        logic [15:0] id;
        logic [10:0] h;
        logic [10:0] v;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   base   = 0;
    int   t_req  = 0;
    logic prev_valid = 1'b0;
    logic prev_err   = 1'b0;

    function automatic void check_output(input string name, input logic [63:0] got,
                                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, got, want);
        end
    endfunction

    function automatic logic [15:0] straps(input logic [2:0] code);
        logic [15:0] r;
        r     = '0;
        r[4]  = code[2];
        r[10] = code[1];
        r[15] = code[0];
        return r;
    endfunction

    // Any rising flag is an output event that must match the head of the scoreboard.
    always @(negedge clk) begin
        if (id_valid && id_err)
            check_output("flags_exclusive", {62'd0, id_valid, id_err}, 64'b10);
        if ((id_valid && !prev_valid) || (id_err && !prev_err)) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_rise", {62'd0, id_valid, id_err}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("flags", {62'd0, id_valid, id_err}, {62'd0, mon_e.valid, mon_e.err});
                check_output("lcd_id", {48'd0, lcd_id}, {48'd0, mon_e.id});
                check_output("resolution", {42'd0, h_disp, v_disp}, {42'd0, mon_e.h, mon_e.v});
                check_output("latency_cycle", 64'(cyc), 64'(mon_e.at));
            end
        end
        prev_valid = id_valid;
        prev_err   = id_err;
    end

    task automatic push_exp(input logic valid, input logic err, input logic [15:0] id,
                            input logic [10:0] h, input logic [10:0] v, input int at);
        exp_t e;
        e.valid = valid;
        e.err   = err;
        e.id    = id;
        e.h     = h;
        e.v     = v;
        e.at    = at;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [2:0] code);
        rst_n   = 1'b0;
        rd_req  = 1'b0;
        lcd_rgb = straps(code);
        repeat (2) @(negedge clk);
        check_output("reset_state", {24'd0, id_valid, id_err, lcd_id, h_disp, v_disp}, 64'd0);
        rst_n = 1'b1;
        base  = cyc;
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check_output("wait_bound", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        rd_req  = 1'b0;
        lcd_rgb = '0;
        @(negedge clk);

        // Known code held from reset.
        apply_stimulus(3'b001);
        push_exp(1'b1, 1'b0, 16'h7084, 11'd800, 11'd480, base + 12);
        wait_drain(60);

        // One-cycle glitch on edge 11 restarts the stability run.
        apply_stimulus(3'b101);
        push_exp(1'b1, 1'b0, 16'h1018, 11'd1280, 11'd800, base + 15);
        repeat (10) @(negedge clk);
        lcd_rgb = straps(3'b100);
        @(negedge clk);
        lcd_rgb = straps(3'b101);
        wait_drain(60);

        // Unknown code.
        apply_stimulus(3'b011);
        push_exp(1'b0, 1'b1, 16'h0000, 11'd0, 11'd0, base + 12);
        wait_drain(60);

        // Straps toggling every edge never settle, so the timeout fires.
        apply_stimulus(3'b000);
        push_exp(1'b0, 1'b1, 16'h0000, 11'd0, 11'd0, base + 40);
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            lcd_rgb = straps({2'b00, i[0]});
        end
        wait_drain(60);

        // Re-detect from DONE, with a second request during SETTLE that must be ignored.
        apply_stimulus(3'b000);
        push_exp(1'b1, 1'b0, 16'h4342, 11'd480, 11'd272, base + 12);
        wait_drain(60);
        lcd_rgb = straps(3'b100);
        rd_req  = 1'b1;
        t_req   = cyc;
        @(negedge clk);
        rd_req = 1'b0;
        check_output("redetect_drop", {24'd0, id_valid, id_err, lcd_id, h_disp, v_disp},
                     {24'd0, 2'b00, 16'h4342, 11'd480, 11'd272});
        push_exp(1'b1, 1'b0, 16'h4384, 11'd800, 11'd480, t_req + 13);
        repeat (2) @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        wait_drain(60);

        // Reset pulse on edge 11, in the middle of SAMPLE.
        apply_stimulus(3'b001);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("mid_sample_reset", {24'd0, id_valid, id_err, lcd_id, h_disp, v_disp}, 64'd0);
        rst_n = 1'b1;
        base  = cyc;
        push_exp(1'b1, 1'b0, 16'h7084, 11'd800, 11'd480, base + 12);
        wait_drain(60);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
